// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution instruction sequencer:
// instruction-word bit positions, the idle word and the FSM state type.
package conv_seq_pkg;

    localparam int INST_W     = 34;
    localparam int FIELD_AW   = 11;   // address field width inside inst

    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_HI    = 30;
    localparam int B_AP_LO    = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX_HI    = 17;
    localparam int B_AX_LO    = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Both SRAMs deselected (active-low CEN/WEN high), every strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        IDLE, W_RD, W_LOAD, W_GAP, X_EXEC, DRAIN, NEXT, DONE
    } state_t;

endpackage

// File: rtl/seq_ofifo_drain.sv
// OFIFO-to-psum drain engine: counts rows read for the current kernel
// position, enforces one idle cycle between reads and generates the
// psum write address kij*len_nij + rd_cnt.
module seq_ofifo_drain #(
    parameter int len_nij = 36,
    parameter int addr_w  = 11,
    parameter int kij_w   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              ofifo_valid,
    input  logic [kij_w-1:0]  kij,
    output logic              fire,
    output logic [addr_w-1:0] a_pmem,
    output logic              rd_done
);

    localparam int CW = $clog2(len_nij + 1);

    logic [CW-1:0] rd_cnt;
    logic          rd_prev;

    // A read issued last cycle has not reached the core yet (inst is
    // registered), so ofifo_valid may still reflect the row just taken.
    assign fire    = enable && ofifo_valid && !rd_prev && (rd_cnt < CW'(len_nij));
    assign rd_done = (rd_cnt == CW'(len_nij));
    assign a_pmem  = addr_w'(int'(kij) * len_nij + int'(rd_cnt));

    // Row counter and read-spacing flag, cleared between kernel positions.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_cnt  <= '0;
            rd_prev <= 1'b0;
        end else begin
            rd_prev <= fire;
            if (fire) rd_cnt <= rd_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/conv_inst_sequencer.sv
// Autonomous instruction sequencer for the systolic core: per kernel
// position loads weights into the PE array, streams activations through
// execute and drains the OFIFO into psum SRAM. Every output is registered.
module conv_inst_sequencer
    import conv_seq_pkg::*;
#(
    parameter int row        = 8,
    parameter int col        = 8,
    parameter int len_nij    = 36,
    parameter int len_kij    = 9,
    parameter int addr_w     = 11,
    parameter int w_base     = 1024,
    parameter int gap_cycles = 10,
    parameter int drain_max  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        kij_idx
);

    localparam int CNT_W = 16;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        kij_nxt;
    logic              err_nxt;
    logic [INST_W-1:0] inst_nxt;

    logic              drain_en, drain_clr, fire, rd_done;
    logic [addr_w-1:0] a_pmem;

    assign drain_en  = (state == X_EXEC || state == DRAIN) && !abort;
    assign drain_clr = (state == IDLE) || (state == NEXT) || abort;

    seq_ofifo_drain #(
        .len_nij (len_nij),
        .addr_w  (addr_w),
        .kij_w   (4)
    ) u_drain (
        .clk         (clk),
        .reset       (reset),
        .clear       (drain_clr),
        .enable      (drain_en),
        .ofifo_valid (ofifo_valid),
        .kij         (kij_idx),
        .fire        (fire),
        .a_pmem      (a_pmem),
        .rd_done     (rd_done)
    );

    // Next-state, counters and next instruction word.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        kij_nxt   = kij_idx;
        err_nxt   = err;
        inst_nxt  = INST_IDLE;
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = W_RD;
                        cnt_nxt   = '0;
                        kij_nxt   = '0;
                        err_nxt   = 1'b0;
                    end
                end
                W_RD: begin
                    if (cnt < CNT_W'(col)) begin
                        inst_nxt[B_CEN_X]         = 1'b0;
                        inst_nxt[B_AX_HI:B_AX_LO] = FIELD_AW'(w_base + int'(cnt));
                    end
                    // SRAM data lands one cycle after its address.
                    if (cnt >= CNT_W'(1)) inst_nxt[B_L0_WR] = 1'b1;
                    if (cnt == CNT_W'(col)) begin
                        state_nxt = W_LOAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                W_LOAD: begin
                    inst_nxt[B_L0_RD] = 1'b1;
                    inst_nxt[B_LOAD]  = 1'b1;
                    if (cnt == CNT_W'(col + row - 1)) begin
                        state_nxt = W_GAP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                W_GAP: begin
                    if (cnt == CNT_W'(gap_cycles - 1)) begin
                        state_nxt = X_EXEC;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                X_EXEC: begin
                    if (cnt < CNT_W'(len_nij)) begin
                        inst_nxt[B_CEN_X]         = 1'b0;
                        inst_nxt[B_AX_HI:B_AX_LO] = FIELD_AW'(cnt);
                    end
                    if (cnt >= CNT_W'(1) && cnt <= CNT_W'(len_nij))
                        inst_nxt[B_L0_WR] = 1'b1;
                    if (cnt >= CNT_W'(2)) begin
                        inst_nxt[B_L0_RD] = 1'b1;
                        inst_nxt[B_EXEC]  = 1'b1;
                    end
                    if (cnt == CNT_W'(len_nij + 1)) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_done) begin
                        state_nxt = NEXT;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(drain_max - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = NEXT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (kij_idx < 4'(len_kij - 1)) begin
                        kij_nxt   = kij_idx + 1'b1;
                        state_nxt = W_RD;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        // Psum write rides on top of whatever the main FSM issues.
        if (fire) begin
            inst_nxt[B_OFIFO_RD]      = 1'b1;
            inst_nxt[B_CEN_P]         = 1'b0;
            inst_nxt[B_WEN_P]         = 1'b0;
            inst_nxt[B_ACC]           = 1'b0;
            inst_nxt[B_AP_HI:B_AP_LO] = FIELD_AW'(a_pmem);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            kij_idx <= '0;
            err     <= 1'b0;
            inst    <= INST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            kij_idx <= kij_nxt;
            err     <= err_nxt;
            inst    <= inst_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_conv_inst_sequencer.sv
// Randomized bench for conv_inst_sequencer: a phase-by-phase reference
// model builds the expected per-cycle output trace of a whole run from the
// ofifo_valid pattern, then the DUT is run and compared cycle by cycle.
module tb_conv_inst_sequencer;

    localparam int ROW = 4, COL = 4, N = 6, LK = 2, GAP = 2, DMAX = 8;
    localparam int W_BASE = 1024;
    localparam int VQ_LEN = 128;
    localparam logic [33:0] IDLE_W = (34'd1 << 32) | (34'd1 << 31) | (34'd1 << 19) | (34'd1 << 18);

    logic        clk = 1'b0;
    logic        reset, start, abort, ofifo_valid;
    logic [33:0] inst;
    logic        busy, done, err;
    logic [3:0]  kij_idx;

    conv_inst_sequencer #(
        .row(ROW), .col(COL), .len_nij(N), .len_kij(LK), .addr_w(11),
        .w_base(W_BASE), .gap_cycles(GAP), .drain_max(DMAX)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done),
        .err(err), .kij_idx(kij_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected trace: entry k = outputs after clock edge k of a run
    logic [33:0] e_inst[$];
    bit          e_busy[$], e_done[$], e_err[$];
    int          e_kij[$];
    bit          vq[VQ_LEN];
    bit          m_err = 0;

    task automatic push(input logic [33:0] w, input bit b, input bit d, input int kk);
        e_inst.push_back(w);
        e_busy.push_back(b);
        e_done.push_back(d);
        e_err.push_back(m_err);
        e_kij.push_back(kk);
    endtask

    // one drain opportunity: read a row if valid, none last cycle, rows left
    task automatic psum(inout logic [33:0] w, inout int rdc, inout bit prev, input int kij);
        bit f;
        int k;
        k = e_inst.size();
        f = (k < VQ_LEN) && vq[k] && !prev && (rdc < N);
        if (f) begin
            w[6]     = 1'b1;
            w[32]    = 1'b0;
            w[31]    = 1'b0;
            w[33]    = 1'b0;
            w[30:20] = 11'(kij * N + rdc);
            rdc++;
        end
        prev = f;
    endtask

    task automatic build(input int mode);
        logic [33:0] w;
        int rdc;
        bit prev;
        e_inst.delete(); e_busy.delete(); e_done.delete(); e_err.delete(); e_kij.delete();
        for (int i = 0; i < VQ_LEN; i++) begin
            case (mode)
                0:       vq[i] = ($urandom_range(0, 1) == 1);
                1:       vq[i] = 1'b1;
                2:       vq[i] = 1'b0;
                default: vq[i] = ($urandom_range(0, 3) != 0);
            endcase
        end
        m_err = 0;
        push(IDLE_W, 1, 0, 0);
        for (int kij = 0; kij < LK; kij++) begin
            for (int c = 0; c <= COL; c++) begin
                w = IDLE_W;
                if (c < COL) begin w[19] = 1'b0; w[17:7] = 11'(W_BASE + c); end
                if (c >= 1) w[2] = 1'b1;
                push(w, 1, 0, kij);
            end
            repeat (COL + ROW) begin
                w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
                push(w, 1, 0, kij);
            end
            repeat (GAP) push(IDLE_W, 1, 0, kij);
            rdc = 0; prev = 0;
            for (int e = 0; e <= N + 1; e++) begin
                w = IDLE_W;
                if (e < N) begin w[19] = 1'b0; w[17:7] = 11'(e); end
                if (e >= 1 && e <= N) w[2] = 1'b1;
                if (e >= 2) begin w[3] = 1'b1; w[1] = 1'b1; end
                psum(w, rdc, prev, kij);
                push(w, 1, 0, kij);
            end
            for (int d = 0; d < DMAX; d++) begin
                w = IDLE_W;
                if (rdc == N) begin push(w, 1, 0, kij); break; end
                psum(w, rdc, prev, kij);
                if (d == DMAX - 1) m_err = 1;
                push(w, 1, 0, kij);
            end
            if (kij < LK - 1) push(IDLE_W, 1, 0, kij + 1);
            else              push(IDLE_W, 1, 1, kij);
        end
        push(IDLE_W, 0, 0, LK - 1);
    endtask

    task automatic run(input int mode, input string nm);
        int  npmem, ndone;
        bit  lastrd, consec;
        npmem = 0; ndone = 0; lastrd = 0; consec = 0;
        build(mode);
        @(negedge clk);
        start = 1'b1; ofifo_valid = vq[0];
        for (int k = 0; k < e_inst.size(); k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, " inst"}, 64'(inst), 64'(e_inst[k]));
            chk({nm, " busy"}, 64'(busy), 64'(e_busy[k]));
            chk({nm, " done"}, 64'(done), 64'(e_done[k]));
            chk({nm, " err"},  64'(err),  64'(e_err[k]));
            chk({nm, " kij"},  64'(kij_idx), 64'(e_kij[k]));
            if (!inst[32] && !inst[31]) npmem++;
            if (done) ndone++;
            if (inst[6] && lastrd) consec = 1;
            lastrd = inst[6];
            // spurious starts while the run is in flight must be ignored
            start = (k + 1 < e_inst.size()) ? ($urandom_range(0, 7) == 0) : 1'b0;
            ofifo_valid = (k + 1 < VQ_LEN) ? vq[k + 1] : 1'b0;
        end
        start = 1'b0; ofifo_valid = 1'b0;
        chk({nm, " done_count"}, 64'(ndone), 64'(1));
        chk({nm, " consec_rd"}, 64'(consec), 64'(0));
        if (mode == 1) chk({nm, " pmem_writes"}, 64'(npmem), 64'(LK * N));
        if (mode == 2) chk({nm, " pmem_writes"}, 64'(npmem), 64'(0));
        repeat (3) begin
            @(negedge clk);
            chk({nm, " idle_inst"}, 64'(inst), 64'(IDLE_W));
            chk({nm, " idle_busy"}, 64'(busy), 64'(0));
            chk({nm, " idle_err"},  64'(err),  64'(m_err));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst inst", 64'(inst), 64'(IDLE_W));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst err",  64'(err),  64'(0));
        chk("rst kij",  64'(kij_idx), 64'(0));
        reset = 1'b0;

        run(1, "held");
        run(0, "rand50");
        run(2, "timeout");
        run(1, "after_to");

        // abort in the middle of execute
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(posedge clk);
        @(negedge clk);
        chk("abort pre_ax", 64'(inst[17:7]), 64'(2));
        chk("abort pre_cen", 64'(inst[19]), 64'(0));
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort inst", 64'(inst), 64'(IDLE_W));
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort err",  64'(err),  64'(0));
        begin
            int nd;
            nd = 0;
            repeat (20) begin
                @(negedge clk);
                if (done || busy) nd++;
            end
            chk("abort quiet", 64'(nd), 64'(0));
        end
        m_err = 0;
        run(3, "restart");

        // reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst inst", 64'(inst), 64'(IDLE_W));
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst kij",  64'(kij_idx), 64'(0));
        m_err = 0;
        run(0, "final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
